// File: rtl/grey_seg_scan.sv
// grey_seg_scan: N-digit ring-code 7-segment scanner with a frame-synchronised double buffer; outputs are registered one clock after (idx,div).
// Optional macro LEADING_ZERO_BLANK_EN suppresses the leading 10001 digits above digit 0.
module grey_seg_scan #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [5*N_DIGITS-1:0]   i_grey,
  input  logic                    i_load,
  input  logic                    i_err_clr,
  output logic [7:0]              o_seg,
  output logic [N_DIGITS-1:0]     o_dig,
  output logic                    o_frame,
  output logic                    o_err
);
  localparam int              DW        = $clog2(REFRESH_DIV);
  localparam int              IW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [4:0]      ZERO_CODE = 5'b10001;
  localparam logic [DW-1:0]   DIV_LAST  = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]   BLANK_END = DW'(BLANK_CYCLES);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(N_DIGITS - 1);

  logic [DW-1:0]           r_div;
  logic [IW-1:0]           r_idx;
  logic [5*N_DIGITS-1:0]   r_pend;
  logic [5*N_DIGITS-1:0]   r_disp;
  logic                    r_pend_v;

  logic [4:0]              w_codes [N_DIGITS];
  logic                    w_slot_end;
  logic                    w_wrap;
  logic                    w_blank;
  logic                    w_hide;
  logic                    w_show;
  logic [8:0]              w_dec;
  logic [N_DIGITS-1:0]     w_onehot;

  // Returns {valid, segments}.
  function automatic logic [8:0] f_decode(input logic [4:0] code);
    case (code)
      5'b10001: f_decode = {1'b1, 8'h3F};
      5'b00001: f_decode = {1'b1, 8'h06};
      5'b00011: f_decode = {1'b1, 8'h5B};
      5'b00010: f_decode = {1'b1, 8'h4F};
      5'b00110: f_decode = {1'b1, 8'h66};
      5'b00100: f_decode = {1'b1, 8'h6D};
      5'b01100: f_decode = {1'b1, 8'h7D};
      5'b01000: f_decode = {1'b1, 8'h07};
      5'b11000: f_decode = {1'b1, 8'h7F};
      5'b10000: f_decode = {1'b1, 8'h6F};
      5'b10101: f_decode = {1'b1, 8'h80};
      default:  f_decode = {1'b0, 8'h40};
    endcase
  endfunction

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_codes
    assign w_codes[g] = r_disp[5*g +: 5];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] w_zero;
  logic [N_DIGITS-1:0] w_supp;
  // A digit is a leading zero when it and everything above it read 10001.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_lzb
    assign w_zero[g] = (w_codes[g] == ZERO_CODE);
    assign w_supp[g] = &w_zero[N_DIGITS-1:g];
  end
  assign w_hide = w_supp[r_idx] && (r_idx != '0);
`else
  assign w_hide = 1'b0;
`endif

  assign w_slot_end = (r_div == DIV_LAST);
  assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
  assign w_blank    = (r_div < BLANK_END);
  assign w_show     = !w_blank && !w_hide;
  assign w_dec      = f_decode(w_codes[r_idx]);

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div    <= '0;
      r_idx    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_disp   <= {N_DIGITS{ZERO_CODE}};
      o_seg    <= '0;
      o_dig    <= '0;
      o_frame  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      r_div <= w_slot_end ? '0 : r_div + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end

      // A load landing on the wrap edge bypasses the pending buffer.
      o_frame <= 1'b0;
      if (w_wrap && i_load) begin
        r_disp   <= i_grey;
        r_pend_v <= 1'b0;
        o_frame  <= 1'b1;
      end else if (w_wrap && r_pend_v) begin
        r_disp   <= r_pend;
        r_pend_v <= 1'b0;
        o_frame  <= 1'b1;
      end else if (i_load) begin
        r_pend   <= i_grey;
        r_pend_v <= 1'b1;
      end

      if (w_show) begin
        o_seg <= w_dec[7:0];
        o_dig <= w_onehot;
      end else begin
        o_seg <= '0;
        o_dig <= '0;
      end

      if (w_show && !w_dec[8]) begin
        o_err <= 1'b1;
      end else if (i_err_clr) begin
        o_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_grey_seg_scan.sv
// Bench for grey_seg_scan (N=4, DIV=8, BLANK=2): cycle model feeds a scoreboard queue.
module tb_grey_seg_scan;
  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [19:0] i_grey = '0;
  logic        i_load = 1'b0;
  logic        i_err_clr = 1'b0;
  logic [7:0]  o_seg;
  logic [3:0]  o_dig;
  logic        o_frame;
  logic        o_err;

  int          n_checks = 0;
  int          n_fail = 0;
  int          m_t;
  logic [4:0]  m_disp [4];
  logic [19:0] m_pend;
  bit          m_pv;
  bit          m_err;
  logic [13:0] sb [$];
  logic [13:0] exp_v;

  grey_seg_scan #(.N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_grey(i_grey), .i_load(i_load), .i_err_clr(i_err_clr),
    .o_seg(o_seg), .o_dig(o_dig), .o_frame(o_frame), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0d", m_t);
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] ref_decode(input logic [4:0] c);
    case (c)
      5'b10001: return {1'b1, 8'h3F};
      5'b00001: return {1'b1, 8'h06};
      5'b00011: return {1'b1, 8'h5B};
      5'b00010: return {1'b1, 8'h4F};
      5'b00110: return {1'b1, 8'h66};
      5'b00100: return {1'b1, 8'h6D};
      5'b01100: return {1'b1, 8'h7D};
      5'b01000: return {1'b1, 8'h07};
      5'b11000: return {1'b1, 8'h7F};
      5'b10000: return {1'b1, 8'h6F};
      5'b10101: return {1'b1, 8'h80};
      default:  return {1'b0, 8'h40};
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0;
    for (int j = 0; j < 4; j++) m_disp[j] = 5'b10001;
    m_pend = '0;
    m_pv = 0;
    m_err = 0;
  endtask

  // One clock: drive inputs, push the model's expectation, advance past the edge.
  task automatic step(input logic ld, input logic [19:0] g, input logic clr);
    int div, idx;
    bit wrap, blank, hide, frm;
    logic [8:0] d;
    logic [7:0] seg;
    logic [3:0] dig;
    @(negedge clk);
    i_load = ld; i_grey = g; i_err_clr = clr;
    div   = m_t % 8;
    idx   = (m_t / 8) % 4;
    wrap  = (m_t % 32) == 31;
    blank = div < 2;
    hide  = 0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0) begin
      hide = 1;
      for (int j = idx; j < 4; j++) if (m_disp[j] != 5'b10001) hide = 0;
    end
`endif
    d = ref_decode(m_disp[idx]);
    if (blank || hide) begin
      seg = 8'h00; dig = 4'b0000;
    end else begin
      seg = d[7:0]; dig = 4'b0001 << idx;
    end
    if (!blank && !hide && !d[8]) m_err = 1;
    else if (clr) m_err = 0;
    frm = wrap && (ld || m_pv);
    if (wrap && ld) begin
      for (int j = 0; j < 4; j++) m_disp[j] = g[5*j +: 5];
      m_pv = 0;
    end else if (wrap && m_pv) begin
      for (int j = 0; j < 4; j++) m_disp[j] = m_pend[5*j +: 5];
      m_pv = 0;
    end else if (ld) begin
      m_pend = g; m_pv = 1;
    end
    sb.push_back({seg, dig, frm, m_err});
    m_t++;
    @(posedge clk);
    #1;
    i_load = 1'b0; i_err_clr = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #12;
    n_checks++;
    if ({o_seg, o_dig, o_frame, o_err} !== 14'h0)
      $display("FAIL reset_state got=%h want=0", {o_seg, o_dig, o_frame, o_err});
    if ({o_seg, o_dig, o_frame, o_err} !== 14'h0) n_fail++;
    @(posedge clk); #2;
    i_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 20'h0, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if ({o_seg, o_dig, o_frame, o_err} !== exp_v) begin
        n_fail++;
        $display("FAIL reset_scan t=%0d got=%h want=%h", m_t - 1, {o_seg, o_dig, o_frame, o_err}, exp_v);
      end
      if (i == 2) begin
        n_checks++;
        if (o_dig !== 4'b0001 || o_seg !== 8'h3F) begin
          n_fail++;
          $display("FAIL first_digit dig=%b seg=%h want 0001/3F", o_dig, o_seg);
        end
      end
    end
  endtask

  task automatic test_load();
    int frames = 0;
    logic [19:0] g = {5'b10000, 5'b01100, 5'b00011, 5'b00001};
    for (int i = 0; i < 75; i++) begin
      step(i == 5, g, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if ({o_seg, o_dig, o_frame, o_err} !== exp_v) begin
        n_fail++;
        $display("FAIL load t=%0d got=%h want=%h", m_t - 1, {o_seg, o_dig, o_frame, o_err}, exp_v);
      end
      frames += int'(o_frame);
    end
    n_checks++;
    if (frames !== 1) begin
      n_fail++;
      $display("FAIL load_frames got=%0d want=1", frames);
    end
  endtask

  task automatic test_err();
    int w;
    logic [19:0] bad  = {5'b10000, 5'b11111, 5'b00011, 5'b00001};
    logic [19:0] good = {5'b00010, 5'b00110, 5'b01000, 5'b00001};
    w = m_t + (31 - m_t % 32);
    for (int i = 0; i < 200 && m_t <= w + 52; i++) begin
      step(i == 0, bad, (m_t >= w + 15) && (m_t <= w + 24));
      exp_v = sb.pop_front(); n_checks++;
      if ({o_seg, o_dig, o_frame, o_err} !== exp_v) begin
        n_fail++;
        $display("FAIL err_set t=%0d got=%h want=%h", m_t - 1, {o_seg, o_dig, o_frame, o_err}, exp_v);
      end
    end
    n_checks++;
    if (o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got=%b want=1", o_err);
    end
    w = m_t + (31 - m_t % 32);
    for (int i = 0; i < 200 && m_t <= w + 3; i++) begin
      step(i == 0, good, m_t == w + 3);
      exp_v = sb.pop_front(); n_checks++;
      if ({o_seg, o_dig, o_frame, o_err} !== exp_v) begin
        n_fail++;
        $display("FAIL err_clr t=%0d got=%h want=%h", m_t - 1, {o_seg, o_dig, o_frame, o_err}, exp_v);
      end
    end
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared got=%b want=0", o_err);
    end
  endtask

  task automatic test_wrap_load();
    int frames = 0;
    logic [19:0] g = {5'b00110, 5'b00100, 5'b01000, 5'b11000};
    for (int i = 0; i < 40 && (m_t % 32) != 31; i++) begin
      step(1'b0, 20'h0, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if ({o_seg, o_dig, o_frame, o_err} !== exp_v) begin
        n_fail++;
        $display("FAIL wrap_pre t=%0d got=%h want=%h", m_t - 1, {o_seg, o_dig, o_frame, o_err}, exp_v);
      end
    end
    for (int i = -1; i < 64; i++) begin
      step(i == -1, g, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if ({o_seg, o_dig, o_frame, o_err} !== exp_v) begin
        n_fail++;
        $display("FAIL wrap_load t=%0d got=%h want=%h", m_t - 1, {o_seg, o_dig, o_frame, o_err}, exp_v);
      end
      frames += int'(o_frame);
      if (i == 2) begin
        n_checks++;
        if (o_seg !== 8'h7F || o_dig !== 4'b0001) begin
          n_fail++;
          $display("FAIL wrap_slot0 seg=%h dig=%b want 7F/0001", o_seg, o_dig);
        end
      end
    end
    n_checks++;
    if (frames !== 1) begin
      n_fail++;
      $display("FAIL wrap_frames got=%0d want=1", frames);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 40 && (m_t % 32) != 20; i++) begin
      step((m_t % 32) == 18, 20'hABCDE, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if ({o_seg, o_dig, o_frame, o_err} !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_pre t=%0d got=%h want=%h", m_t - 1, {o_seg, o_dig, o_frame, o_err}, exp_v);
      end
    end
    #3;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_seg !== 8'h00 || o_dig !== 4'b0000 || o_frame !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_dark seg=%h dig=%b want 00/0000", o_seg, o_dig);
    end
    @(posedge clk); #2;
    i_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 20'h0, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if ({o_seg, o_dig, o_frame, o_err} !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_post t=%0d got=%h want=%h", m_t - 1, {o_seg, o_dig, o_frame, o_err}, exp_v);
      end
      if (i == 2) begin
        n_checks++;
        if (o_dig !== 4'b0001 || o_seg !== 8'h3F) begin
          n_fail++;
          $display("FAIL rstmid_restart dig=%b seg=%h want 0001/3F", o_dig, o_seg);
        end
      end
    end
  endtask

  task automatic test_lzb();
    int w;
    logic [19:0] g = {5'b10001, 5'b10001, 5'b00001, 5'b10001};
    w = m_t + (31 - m_t % 32);
    for (int i = 0; i < 200 && m_t <= w + 33; i++) begin
      step(i == 0, g, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if ({o_seg, o_dig, o_frame, o_err} !== exp_v) begin
        n_fail++;
        $display("FAIL lzb t=%0d got=%h want=%h", m_t - 1, {o_seg, o_dig, o_frame, o_err}, exp_v);
      end
      if (m_t - 1 == w + 13) begin
        n_checks++;
        if (o_seg !== 8'h06 || o_dig !== 4'b0010) begin
          n_fail++;
          $display("FAIL lzb_slot1 seg=%h dig=%b want 06/0010", o_seg, o_dig);
        end
      end
      if (m_t - 1 == w + 29) begin
        n_checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (o_seg !== 8'h00 || o_dig !== 4'b0000) begin
          n_fail++;
          $display("FAIL lzb_slot3 seg=%h dig=%b want 00/0000", o_seg, o_dig);
        end
`else
        if (o_seg !== 8'h3F || o_dig !== 4'b1000) begin
          n_fail++;
          $display("FAIL lzb_slot3 seg=%h dig=%b want 3F/1000", o_seg, o_dig);
        end
`endif
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_load();
    test_err();
    test_wrap_load();
    test_reset_mid();
    test_lzb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
